result_writeback: RTL

RESULT_WRITEBACK -- requirements
Module: result_writeback

---
 rtl/result_writeback.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/result_writeback.sv
// Result writeback buffer.
// Captures four accumulated lane words per Capture strobe into a two-entry FIFO.
// Drains each set as four sequential words (lane 0..3) to an addressed sink.
// The sink uses a valid/ready handshake.
// Address counter auto-increments per word and wraps at 2^ADDR_WIDTH.
module result_writeback #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int RELU_EN    = 1
) (
    input  logic                    Clk,
    input  logic                    rst,
    input  logic [4*DATA_WIDTH-1:0] Input_data_0,
    input  logic [4*DATA_WIDTH-1:0] Input_data_1,
    input  logic [4*DATA_WIDTH-1:0] Input_data_2,
    input  logic [4*DATA_WIDTH-1:0] Input_data_3,
    input  logic                    Capture,
    output logic                    Capture_ready,
    input  logic                    Addr_load,
    input  logic [ADDR_WIDTH-1:0]   Base_addr,
    output logic [4*DATA_WIDTH-1:0] Out_data,
    output logic [ADDR_WIDTH-1:0]   Out_addr,
    output logic                    Out_valid,
    input  logic                    Out_ready,
    output logic                    Busy,
    output logic                    Overflow_err
);

    localparam int W = 4 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    logic [W-1:0]          r_fifo [2][4];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  r_ovf;

    state_t                r_state;
    logic [1:0]            r_lane;
    logic [W-1:0]          r_out_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_out_valid;

    logic                  w_cap_ready;
    logic                  w_push;
    logic                  w_xfer;
    logic                  w_pop;
    logic                  w_more;
    logic [W-1:0]          w_next_word0;

    function automatic logic [W-1:0] relu(input logic [W-1:0] d);
        if (RELU_EN != 0 && d[W-1])
            return '0;
        return d;
    endfunction

    // Capture acceptance ignores a same-cycle drain; a full FIFO always refuses.
    assign w_cap_ready = (r_count != 2'd2);
    assign w_push      = Capture & w_cap_ready;
    assign w_xfer      = r_out_valid & Out_ready;
    assign w_pop       = w_xfer & (r_lane == 2'd3);
    // Another set is ready after a pop.
    // It is either already stored, or being captured on this same edge.
    assign w_more      = (r_count == 2'd2) | w_push;

    // First word of the set that follows the head.
    // When that set is being captured on this edge, bypass straight from the inputs.
    always_comb begin
        w_next_word0 = Input_data_0;
        if (r_count == 2'd2)
            w_next_word0 = r_fifo[~r_rd_ptr][0];
    end

    // Result set storage; validity is tracked by the count, so no reset is needed.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr][0] <= Input_data_0;
            r_fifo[r_wr_ptr][1] <= Input_data_1;
            r_fifo[r_wr_ptr][2] <= Input_data_2;
            r_fifo[r_wr_ptr][3] <= Input_data_3;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (Capture && !w_cap_ready)
                r_ovf <= 1'b1;
        end
    end

    // Drain FSM with registered word, address and valid outputs.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lane      <= 2'd0;
            r_out_data  <= '0;
            r_addr      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Addr_load && r_count == 2'd0)
                        r_addr <= Base_addr;
                    if (w_push) begin
                        r_state     <= S_SEND;
                        r_lane      <= 2'd0;
                        r_out_data  <= relu(Input_data_0);
                        r_out_valid <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        r_addr <= r_addr + ADDR_ONE;
                        if (r_lane != 2'd3) begin
                            r_lane     <= r_lane + 2'd1;
                            r_out_data <= relu(r_fifo[r_rd_ptr][r_lane + 2'd1]);
                        end else if (w_more) begin
                            r_lane     <= 2'd0;
                            r_out_data <= relu(w_next_word0);
                        end else begin
                            r_state     <= S_IDLE;
                            r_lane      <= 2'd0;
                            r_out_data  <= '0;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign Capture_ready = w_cap_ready;
    assign Busy          = (r_count != 2'd0);
    assign Overflow_err  = r_ovf;
    assign Out_data      = r_out_data;
    assign Out_addr      = r_addr;
    assign Out_valid     = r_out_valid;

endmodule
